// File: rtl/arp_resolve_ctrl.sv
// ARP resolution controller: arbitrates two requesters, queries the ARP cache and
// issues ARP requests with timed retries. Define ARP_RESOLVE_GATEWAY_EN for gateway routing.
module arp_resolve_ctrl #(
    parameter int unsigned RETRY_COUNT    = 4,
    parameter int unsigned RETRY_INTERVAL = 125000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_ip,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_ip,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_id,
    output logic        resp_error,
    output logic [47:0] resp_mac,
    output logic        cache_req_valid,
    input  logic        cache_req_ready,
    output logic [31:0] cache_req_ip,
    input  logic        cache_resp_valid,
    output logic        cache_resp_ready,
    input  logic        cache_resp_error,
    input  logic [47:0] cache_resp_mac,
    output logic        arp_tx_valid,
    input  logic        arp_tx_ready,
    output logic [31:0] arp_tx_ip,
    input  logic        arp_rx_valid,
    input  logic [31:0] arp_rx_ip,
    input  logic [47:0] arp_rx_mac,
    input  logic [31:0] local_ip,
    input  logic [31:0] gateway_ip,
    input  logic [31:0] subnet_mask
);

    localparam int unsigned TW = $clog2(RETRY_INTERVAL);
    localparam int unsigned RW = $clog2(RETRY_COUNT + 1);

    typedef enum logic [2:0] {
        IDLE,
        QUERY,
        WAIT_CACHE,
        SEND_ARP,
        WAIT_REPLY,
        RESPOND
    } state_t;

    state_t          state_q, state_d;
    logic            rr_q, rr_d;
    logic            id_q, id_d;
    logic [31:0]     hop_q, hop_d;
    logic [47:0]     mac_q, mac_d;
    logic            err_q, err_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [RW-1:0]   retries_q, retries_d;

    logic            sel;
    logic [31:0]     sel_ip;
    logic [31:0]     sel_hop;
    logic            sel_bcast;
    logic            req_fire;

    // rr_q names the requester favoured when both are valid.
    assign sel      = (req0_valid && req1_valid) ? rr_q : req1_valid;
    assign sel_ip   = sel ? req1_ip : req0_ip;
    assign req_fire = rst_n && (state_q == IDLE) && (req0_valid || req1_valid);

`ifdef ARP_RESOLVE_GATEWAY_EN
    assign sel_bcast = (sel_ip == '1) || (sel_ip == (local_ip | ~subnet_mask));
    assign sel_hop   = ((sel_ip & subnet_mask) == (local_ip & subnet_mask)) ? sel_ip : gateway_ip;
`else
    logic cfg_unused;
    assign cfg_unused = ^{local_ip, gateway_ip, subnet_mask};
    assign sel_bcast  = (sel_ip == '1);
    assign sel_hop    = sel_ip;
`endif

    assign req0_ready       = req_fire && !sel;
    assign req1_ready       = req_fire && sel;
    assign cache_req_valid  = (state_q == QUERY);
    assign cache_req_ip     = hop_q;
    assign cache_resp_ready = (state_q == WAIT_CACHE);
    assign arp_tx_valid     = (state_q == SEND_ARP);
    assign arp_tx_ip        = hop_q;
    assign resp_valid       = (state_q == RESPOND);
    assign resp_id          = id_q;
    assign resp_error       = err_q;
    assign resp_mac         = mac_q;

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        id_d      = id_q;
        hop_d     = hop_q;
        mac_d     = mac_q;
        err_d     = err_q;
        timer_d   = timer_q;
        retries_d = retries_q;
        case (state_q)
            IDLE: begin
                if (req_fire) begin
                    id_d  = sel;
                    hop_d = sel_hop;
                    if (sel_bcast) begin
                        mac_d   = '1;
                        err_d   = 1'b0;
                        state_d = RESPOND;
                    end else begin
                        state_d = QUERY;
                    end
                end
            end
            QUERY: begin
                if (cache_req_ready) state_d = WAIT_CACHE;
            end
            WAIT_CACHE: begin
                if (cache_resp_valid) begin
                    if (!cache_resp_error) begin
                        mac_d   = cache_resp_mac;
                        err_d   = 1'b0;
                        state_d = RESPOND;
                    end else begin
                        retries_d = RW'(RETRY_COUNT);
                        state_d   = SEND_ARP;
                    end
                end
            end
            SEND_ARP: begin
                if (arp_tx_ready) begin
                    timer_d = TW'(RETRY_INTERVAL - 1);
                    state_d = WAIT_REPLY;
                end
            end
            WAIT_REPLY: begin
                // A matching reply wins over an expiring timer in the same cycle.
                if (arp_rx_valid && (arp_rx_ip == hop_q)) begin
                    mac_d   = arp_rx_mac;
                    err_d   = 1'b0;
                    state_d = RESPOND;
                end else if (timer_q == '0) begin
                    if (retries_q > RW'(1)) begin
                        retries_d = retries_q - RW'(1);
                        state_d   = SEND_ARP;
                    end else begin
                        mac_d   = '0;
                        err_d   = 1'b1;
                        state_d = RESPOND;
                    end
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            RESPOND: begin
                if (resp_ready) begin
                    rr_d    = !id_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rr_q      <= 1'b0;
            id_q      <= 1'b0;
            hop_q     <= '0;
            mac_q     <= '0;
            err_q     <= 1'b0;
            timer_q   <= '0;
            retries_q <= '0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            id_q      <= id_d;
            hop_q     <= hop_d;
            mac_q     <= mac_d;
            err_q     <= err_d;
            timer_q   <= timer_d;
            retries_q <= retries_d;
        end
    end

endmodule

// File: doc/arp_resolve_ctrl.md
ARP_RESOLVE_CTRL -- requirements
Module: arp_resolve_ctrl

Interface
REQ-001 Parameter: RETRY_COUNT, default 4, number of ARP requests sent before reporting failure (>=1).
REQ-002 Parameter: RETRY_INTERVAL, default 125000, clock cycles waited for a reply after each ARP request (>=2).
REQ-003 clk  in  1  clock; all logic on rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 req0_valid/req0_ready/req0_ip  in/out/in  1/1/32  requester 0 IP-to-MAC resolution request.
REQ-006 req1_valid/req1_ready/req1_ip  in/out/in  1/1/32  requester 1 IP-to-MAC resolution request.
REQ-007 resp_valid/resp_ready/resp_id/resp_error/resp_mac  out/in/out/out/out  1/1/1/1/48  result; resp_id = granted requester.
REQ-008 cache_req_valid/cache_req_ready/cache_req_ip  out/in/out  1/1/32  ARP cache query.
REQ-009 cache_resp_valid/cache_resp_ready/cache_resp_error/cache_resp_mac  in/out/in/in  1/1/1/48  ARP cache answer.
REQ-010 arp_tx_valid/arp_tx_ready/arp_tx_ip  out/in/out  1/1/32  command to transmit an ARP request for arp_tx_ip.
REQ-011 arp_rx_valid/arp_rx_ip/arp_rx_mac  in/in/in  1/32/48  single-cycle strobe for a received ARP reply.
REQ-012 local_ip/gateway_ip/subnet_mask  in  32 each  static configuration.

Function
REQ-013 FSM states SHALL be IDLE, QUERY, WAIT_CACHE, SEND_ARP, WAIT_REPLY, RESPOND; one request is processed at a time.
REQ-014 In IDLE, reqN_ready SHALL be high only for the requester selected by round-robin: with both valid, grant the one not served last; with one valid, grant it.
REQ-015 On a handshake, the block SHALL latch the IP and id and compute next_hop = ip if (ip & subnet_mask) == (local_ip & subnet_mask), else gateway_ip.
REQ-016 If ip == 32'hFFFFFFFF or ip == (local_ip | ~subnet_mask), the block SHALL go to RESPOND with resp_mac 48'hFFFFFFFFFFFF and resp_error 0, with no cache query.
REQ-017 Otherwise the block SHALL go to QUERY; cache_req_valid SHALL assert the cycle after acceptance with cache_req_ip = next_hop and hold until cache_req_ready.
REQ-018 In WAIT_CACHE, cache_resp_ready SHALL be 1; on cache_resp_valid with error 0, go to RESPOND with resp_mac = cache_resp_mac.
REQ-019 On a cache miss (error 1), load retries = RETRY_COUNT and go to SEND_ARP; arp_tx_valid is held with arp_tx_ip = next_hop until arp_tx_ready.
REQ-020 After the arp_tx handshake, load timer = RETRY_INTERVAL-1 and go to WAIT_REPLY; the timer decrements once per cycle.
REQ-021 In WAIT_REPLY, arp_rx_valid with arp_rx_ip == next_hop SHALL go to RESPOND with resp_mac = arp_rx_mac and error 0; non-matching replies are ignored.
REQ-022 When timer == 0 with no match: if retries > 1, decrement retries and return to SEND_ARP; else go to RESPOND with error 1 and resp_mac 0.
REQ-023 A matching reply in the same cycle the timer reaches 0 SHALL take priority (success).
REQ-024 arp_rx strobes outside WAIT_REPLY SHALL be ignored.
REQ-025 In RESPOND, resp_valid SHALL be held with stable resp_id/error/mac until resp_ready, then return to IDLE and record the served id for round-robin.
REQ-026 Hit latency SHALL be: request accepted cycle N, cache_req_valid at N+1; resp_valid 1 cycle after the cache_resp handshake.

Reset
REQ-027 While rst_n is 0 at a clock edge: state IDLE, round-robin pointer 0, timer and retries 0, and all valid/ready outputs 0; resp_id/resp_error/resp_mac/cache_req_ip/arp_tx_ip SHALL be 0.
REQ-028 Reset mid-operation SHALL abandon the request with no response; the first cycle after reset deassertion SHALL be IDLE.

Configuration
REQ-029 Macro ARP_RESOLVE_GATEWAY_EN: when defined, next_hop follows REQ-015 and the subnet broadcast in REQ-016 applies.
REQ-030 When not defined: next_hop = ip always, only 32'hFFFFFFFF is treated as broadcast, and gateway_ip/subnet_mask are present but ignored.

Verification (local_ip C0A80164, mask FFFFFF00, gateway C0A80101, RETRY_COUNT 2, RETRY_INTERVAL 10)
REQ-031 req0 ip C0A80105, cache hit mac 020000000005 -> cache_req_ip C0A80105; resp id 0, error 0, mac 020000000005.
REQ-032 req0 ip 08080808 (with macro) -> cache_req_ip C0A80101; without macro -> 08080808.
REQ-033 req1 ip C0A801FF -> resp mac FFFFFFFFFFFF, error 0, no cache_req_valid.
REQ-034 Cache miss for C0A80107, no reply -> exactly 2 arp_tx handshakes spaced 10 cycles of WAIT_REPLY apart; then resp error 1, mac 0.
REQ-035 Miss for C0A80107; during WAIT_REPLY drive arp_rx C0A80108 then C0A80107/020000000007 -> first ignored, resp mac 020000000007. Then req0 and req1 held valid together -> grants alternate 0,1,0,1; rst_n low in WAIT_REPLY -> no response, IDLE after release.
